// File: rtl/rvv_alu_seq.sv
// Vector ALU issue sequencer: accepts an instruction, counts element groups down per lane beat,
// and hands back a one-cycle done pulse. Define RVV_SEQ_WATCHDOG_EN to add a RUN-state watchdog.
module rvv_alu_seq #(
    parameter int unsigned VLEN        = 17'd128,
    parameter int unsigned LANE_WIDTH  = 3'b011,
    parameter int unsigned NB_LANES    = 1,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [16:0] issue_vl,
    input  logic [2:0]  issue_vsew,
    input  logic        issue_mask,
    input  logic        abort,
    output logic        alu_run,
    output logic [16:0] alu_arith_remaining,
    input  logic        alu_done,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    localparam logic [16:0] LP_VLEN  = 17'(VLEN);
    localparam logic [16:0] LP_LANES = 17'(1 << NB_LANES);
    localparam logic [3:0]  LP_LW    = 4'(LANE_WIDTH);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_vsew;
    logic [16:0] r_remaining;
    logic [10:0] r_beat;

    logic [3:0]  w_sew_shift;
    logic [16:0] w_cap;
    logic [16:0] w_elems;
    logic [3:0]  w_run_bits;
    logic [10:0] w_beats_m1;
    logic        w_beat_last;
    logic [16:0] w_dec;
    logic        w_wdog_trip;

    // Element count is fixed at accept time, so only vsew must be kept for beat pacing.
    assign w_sew_shift = {1'b0, issue_vsew} + 4'd3;
    assign w_cap       = LP_VLEN >> w_sew_shift;
    assign w_elems     = issue_mask ? w_cap : ((issue_vl < w_cap) ? issue_vl : w_cap);

    assign w_run_bits  = {1'b0, r_vsew} + 4'd3;
    assign w_beats_m1  = (w_run_bits <= LP_LW) ? 11'd0
                                               : ((11'd1 << (w_run_bits - LP_LW)) - 11'd1);
    assign w_beat_last = (r_beat == w_beats_m1);
    assign w_dec       = (r_remaining < LP_LANES) ? r_remaining : LP_LANES;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (issue_valid) w_state_next = (w_elems == 17'd0) ? S_FLUSH : S_RUN;
            S_RUN:   if (abort || alu_done || w_wdog_trip) w_state_next = S_FLUSH;
            S_FLUSH: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_vsew      <= 3'd0;
            r_remaining <= 17'd0;
            r_beat      <= 11'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (issue_valid) begin
                        r_vsew      <= issue_vsew;
                        r_remaining <= w_elems;
                        r_beat      <= 11'd0;
                    end
                end
                S_RUN: begin
                    // Leaving RUN clears the count so the done cycle always reports zero.
                    if (w_state_next == S_FLUSH) begin
                        r_remaining <= 17'd0;
                        r_beat      <= 11'd0;
                    end else if (w_beat_last) begin
                        r_beat      <= 11'd0;
                        r_remaining <= r_remaining - w_dec;
                    end else begin
                        r_beat <= r_beat + 11'd1;
                    end
                end
                default: begin
                    r_remaining <= 17'd0;
                    r_beat      <= 11'd0;
                end
            endcase
        end
    end

`ifdef RVV_SEQ_WATCHDOG_EN
    logic [31:0] r_wdog;
    logic        r_err;

    assign w_wdog_trip = (r_state == S_RUN) && !alu_done && !abort
                         && (r_wdog == 32'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= 32'd0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= (r_state == S_RUN) ? r_wdog + 32'd1 : 32'd0;
            if (w_wdog_trip) r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_wdog_trip = 1'b0;
    assign err         = 1'b0;
`endif

    assign issue_ready         = (r_state == S_IDLE);
    assign alu_run             = (r_state == S_RUN);
    assign busy                = (r_state != S_IDLE);
    assign done                = (r_state == S_FLUSH);
    assign alu_arith_remaining = r_remaining;
endmodule

// File: doc/rvv_alu_seq.md
RVV_ALU_SEQ -- requirements
Module: rvv_alu_seq

Interface
REQ-001 SHALL have parameter VLEN, default 17'd128, vector register length in bits.
REQ-002 SHALL have parameter LANE_WIDTH, default 3'b011, log2 of lane width in bits.
REQ-003 SHALL have parameter NB_LANES, default 1, log2 of lane count; L = 1<<NB_LANES.
REQ-004 SHALL have parameter WDOG_CYCLES, default 1024, watchdog limit in cycles.
REQ-005 Ports:
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-high
  issue_valid  in  1  instruction offered
  issue_ready  out  1  sequencer can accept
  issue_vl  in  17  vector length
  issue_vsew  in  3  element width code
  issue_mask  in  1  mask instruction, process whole register
  abort  in  1  kill current instruction
  alu_run  out  1  run to ALU wrapper
  alu_arith_remaining  out  17  elements not yet issued
  alu_done  in  1  wrapper completion pulse
  busy  out  1  instruction in flight
  done  out  1  one-cycle completion pulse
  err  out  1  sticky watchdog error (see Configuration)

Function
REQ-006 SHALL implement states IDLE, RUN, FLUSH.
REQ-007 IDLE: issue_ready=1, alu_run=0; on issue_valid latch vl, vsew, mask and go to RUN next cycle.
REQ-008 On accept SHALL compute E = VLEN>>(vsew+3) if mask, else min(vl, VLEN>>(vsew+3)); alu_arith_remaining <= E.
REQ-009 If E==0 SHALL go directly to FLUSH without asserting alu_run.
REQ-010 RUN: alu_run=1, issue_ready=0, busy=1.
REQ-011 Beats per element group B = 1 when vsew+3 <= LANE_WIDTH, else 1<<(vsew+3-LANE_WIDTH); sub-beat counter counts 0..B-1.
REQ-012 On last sub-beat SHALL set remaining <= remaining - min(remaining, L), saturating at 0.
REQ-013 alu_done high in RUN SHALL move to FLUSH next cycle regardless of remaining.
REQ-014 abort high in RUN SHALL move to FLUSH next cycle; abort has priority over alu_done; abort ignored in IDLE/FLUSH.
REQ-015 FLUSH: alu_run=0 for exactly one cycle, done=1 for that cycle, remaining <= 0, then IDLE.
REQ-016 Back-to-back: issue accepted in IDLE cycle after FLUSH; minimum one run-low cycle between instructions.
REQ-017 busy SHALL be 1 in RUN and FLUSH, 0 in IDLE.
REQ-018 Latched vl/vsew/mask SHALL not change while busy.

Reset
REQ-019 reset SHALL asynchronously force IDLE, alu_run=0, remaining=0, sub-beat=0, done=0, busy=0, err=0, issue_ready=1 once released.
REQ-020 reset mid-RUN SHALL drop alu_run immediately; no done pulse.

Configuration
REQ-021 Macro RVV_SEQ_WATCHDOG_EN: when defined, cycle counter runs in RUN; reaching WDOG_CYCLES without alu_done SHALL set err (sticky until reset) and force FLUSH.
REQ-022 Without RVV_SEQ_WATCHDOG_EN: no counter, err tied 0, RUN waits indefinitely for alu_done/abort.

Verification
REQ-023 vl=4, vsew=0, mask=0, NB_LANES=1 -> E=4; remaining 4,2,0 on successive RUN cycles; alu_done after 2 cycles -> done pulse, IDLE.
REQ-024 vsew=3 (64b), LANE_WIDTH=3, vl=2 -> B=8; remaining drops 2->0 after 8 cycles.
REQ-025 mask=1, vl=3, vsew=0 -> E=16; vl=0 mask=0 -> no alu_run, done next cycle.
REQ-026 abort and alu_done same cycle in RUN -> single FLUSH cycle, single done pulse.
REQ-027 reset asserted mid-RUN -> alu_run low same cycle, IDLE, no done.
REQ-028 RVV_SEQ_WATCHDOG_EN, WDOG_CYCLES=16, alu_done held low -> err=1 after 16 RUN cycles, FLUSH, err stays 1 until reset.
